// File: rtl/hazard_scoreboard_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit_pkg
// Shared definitions for the hazard control unit: FSM state encoding, the
// default write-back distance / load latency, and a helper that sizes the
// per-register scoreboard counters.
// Optional feature macro used by the unit: HCU_FORWARD_EN.
// ---------------------------------------------------------------------------
package hazard_scoreboard_unit_pkg;

   localparam int WB_DIST_DEFAULT  = 3;
   localparam int LOAD_LAT_DEFAULT = 1;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      FREEZE      = 2'd1,
      FREEZE_PEND = 2'd2
   } hcu_state_e;

   // Bits needed to hold any value in 0..max_val.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_scoreboard.sv
// ---------------------------------------------------------------------------
// hcu_scoreboard
// One down-counter per architectural register. A nonzero counter marks a
// register whose result is not yet readable from the register file.
//
// Ports
//   clk          in   clock
//   clear        in   synchronous clear of every counter (highest priority)
//   hold         in   freeze all counters (no decrement, no set)
//   set_en       in   load counter[set_addr] with set_val this cycle
//   set_addr     in   REG_ADDR_W  register being loaded
//   set_val      in   CNT_W       value loaded
//   look_a_addr  in   REG_ADDR_W  first lookup address
//   look_b_addr  in   REG_ADDR_W  second lookup address
//   look_a_busy  out  counter[look_a_addr] is nonzero
//   look_b_busy  out  counter[look_b_addr] is nonzero
// ---------------------------------------------------------------------------
module hcu_scoreboard
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int REG_ADDR_W = 2,
   parameter int CNT_W      = 2
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  hold,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic [CNT_W-1:0]      set_val,
   input  logic [REG_ADDR_W-1:0] look_a_addr,
   input  logic [REG_ADDR_W-1:0] look_b_addr,
   output logic                  look_a_busy,
   output logic                  look_b_busy
);

   localparam int NUM_REGS = 2 ** REG_ADDR_W;

   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];

   // A reload on the same register beats the per-cycle decrement.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clear) begin
            cnt_d[i] = '0;
         end else if (!hold) begin
            if (set_en && (set_addr == REG_ADDR_W'(i))) begin
               cnt_d[i] = set_val;
            end else if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign look_a_busy = (cnt_q[look_a_addr] != '0);
   assign look_b_busy = (cnt_q[look_b_addr] != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit
// Pipeline hazard control: scoreboard-based RAW detection in ID, branch /
// jump misprediction flushes, and a freeze while data memory is busy. A
// branch miss seen during a freeze is remembered and flushed in the first
// running cycle afterwards.
//
// Optional feature: define HCU_FORWARD_EN to model a forwarding datapath
// (loads block for LOAD_LAT cycles, other writers never block). Without it
// every writer blocks readers for WB_DIST cycles.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   id_valid                     valid instruction in ID
//   id_rs, id_rt                 source registers; id_use_rs/id_use_rt qualify
//   id_reg_write, id_dest        ID instruction writes id_dest
//   id_is_load                   ID instruction is a load
//   branch_miss_ex               mispredicted conditional branch in EX
//   jump_miss_id                 mispredicted jump in ID
//   d_mem_ready                  data memory ready (low = freeze)
//   pc_write, ir_write           PC / IF-ID load enables
//   stall_ifid, stall_idex       hold IF/ID, ID/EX
//   flush_ifid, flush_idex       bubble into IF/ID, ID/EX
//   hcu_state                    FSM state for debug
// ---------------------------------------------------------------------------
module hazard_scoreboard_unit
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int REG_ADDR_W = 2,
   parameter int WB_DIST    = WB_DIST_DEFAULT,
   parameter int LOAD_LAT   = LOAD_LAT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   input  logic                  id_reg_write,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_is_load,
   input  logic                  branch_miss_ex,
   input  logic                  jump_miss_id,
   input  logic                  d_mem_ready,
   output logic                  pc_write,
   output logic                  ir_write,
   output logic                  stall_ifid,
   output logic                  stall_idex,
   output logic                  flush_ifid,
   output logic                  flush_idex,
   output logic [1:0]            hcu_state
);

   // Counters must hold whichever load value the build can use.
   localparam int MAX_LAT = (LOAD_LAT > WB_DIST) ? LOAD_LAT : WB_DIST;
   localparam int CNT_W   = cnt_width(MAX_LAT);

   hcu_state_e state_q, state_d;
   logic       pend_q, pend_d;

   logic             rs_busy, rt_busy;
   logic             frozen, data_hazard, branch_flush, issue, sb_set;
   logic [CNT_W-1:0] load_val;

   assign frozen       = (state_q != RUN) || !d_mem_ready;
   assign data_hazard  = id_valid && ((id_use_rs && rs_busy) || (id_use_rt && rt_busy));
   // A latched branch miss is replayed as if branch_miss_ex were high.
   assign branch_flush = branch_miss_ex || pend_q;
   assign issue        = id_valid && !data_hazard && !branch_flush && !frozen;
   assign sb_set       = issue && id_reg_write;

`ifdef HCU_FORWARD_EN
   assign load_val = id_is_load ? CNT_W'(LOAD_LAT) : '0;
`else
   logic unused_is_load;
   assign unused_is_load = id_is_load;
   assign load_val       = CNT_W'(WB_DIST);
`endif

   hcu_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .CNT_W      (CNT_W)
   ) u_sb (
      .clk         (clk),
      .clear       (!reset_n),
      .hold        (frozen),
      .set_en      (sb_set),
      .set_addr    (id_dest),
      .set_val     (load_val),
      .look_a_addr (id_rs),
      .look_b_addr (id_rt),
      .look_a_busy (rs_busy),
      .look_b_busy (rt_busy)
   );

   // Next state. A branch miss arriving in FREEZE is latched even if memory
   // becomes ready the same cycle; the flag survives until a running cycle
   // consumes it.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      unique case (state_q)
         RUN: begin
            if (!d_mem_ready) begin
               state_d = FREEZE;
            end else begin
               pend_d = 1'b0;
            end
         end
         FREEZE: begin
            if (branch_miss_ex) begin
               pend_d = 1'b1;
            end
            if (d_mem_ready) begin
               state_d = RUN;
            end else if (branch_miss_ex) begin
               state_d = FREEZE_PEND;
            end
         end
         FREEZE_PEND: begin
            if (d_mem_ready) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            pend_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= RUN;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   // Output decode: reset > freeze > branch miss > jump miss > data hazard.
   // A jump miss leaves ID/EX free so the ID instruction proceeds.
   always_comb begin
      pc_write   = 1'b1;
      ir_write   = 1'b1;
      stall_ifid = 1'b0;
      stall_idex = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      if (!reset_n) begin
         pc_write = 1'b1;
      end else if (frozen) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         stall_ifid = 1'b1;
         stall_idex = 1'b1;
      end else if (branch_flush) begin
         ir_write   = 1'b0;
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else if (jump_miss_id) begin
         ir_write   = 1'b0;
         flush_ifid = 1'b1;
      end else if (data_hazard) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         stall_ifid = 1'b1;
         flush_idex = 1'b1;
      end
   end

   assign hcu_state = state_q;

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 2, meaning the register address width; NUM_REGS = 2**REG_ADDR_W.
REQ-002 The block SHALL have parameter WB_DIST, default 3, meaning the cycles from issue out of ID until the result is readable in the register file.
REQ-003 The block SHALL have parameter LOAD_LAT, default 1, meaning the bubbles a dependent instruction needs after a load when forwarding is on.
REQ-004 clk  in  1  clock; the block has one clock only.
REQ-005 reset_n  in  1  reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-006 id_valid  in  1  a valid instruction is present in ID.
REQ-007 id_rs, id_rt  in  REG_ADDR_W each  source register addresses of the ID instruction.
REQ-008 id_use_rs, id_use_rt  in  1 each  set when the ID instruction actually reads that source.
REQ-009 id_reg_write  in  1  set when the ID instruction writes a register.
REQ-010 id_dest  in  REG_ADDR_W  destination register of the ID instruction.
REQ-011 id_is_load  in  1  set when the ID instruction is a load.
REQ-012 branch_miss_ex  in  1  a conditional branch resolved in EX was mispredicted.
REQ-013 jump_miss_id  in  1  an unconditional jump detected in ID was mispredicted.
REQ-014 d_mem_ready  in  1  data memory is ready; low means the access is still in progress.
REQ-015 pc_write, ir_write  out  1 each  enable PC update and IF/ID load.
REQ-016 stall_ifid, stall_idex  out  1 each  hold the IF/ID or ID/EX register.
REQ-017 flush_ifid, flush_idex  out  1 each  insert a bubble into IF/ID or ID/EX.
REQ-018 hcu_state  out  2  current FSM state, for debug.

Function
REQ-019 Scoreboard: the block SHALL keep one counter per register, each wide enough for WB_DIST; a nonzero counter means the register has a pending write.
REQ-020 Data hazard: the block SHALL flag a data hazard when id_valid is set and a used source (id_use_rs or id_use_rt) maps to a nonzero counter.
REQ-021 Issue: an instruction SHALL issue when id_valid is set and there is no data hazard, no flush and no freeze.
REQ-022 On issue with id_reg_write set, the block SHALL load counter[id_dest] with the value in REQ-032.
REQ-023 In every non-frozen cycle, all counters SHALL decrement, saturating at 0.
REQ-024 If a counter reloads and decrements in the same cycle, the reload SHALL win.
REQ-025 FSM states SHALL be RUN=0, FREEZE=1 and FREEZE_PEND=2.
REQ-026 RUN to FREEZE SHALL occur when d_mem_ready=0; FREEZE to RUN when d_mem_ready=1.
REQ-027 A branch_miss_ex asserted while in FREEZE SHALL be latched and the FSM SHALL move to FREEZE_PEND.
REQ-028 FREEZE_PEND SHALL return to RUN when d_mem_ready=1, and SHALL then perform the branch flush in that first RUN cycle.
REQ-029 While frozen (FREEZE or FREEZE_PEND), or when d_mem_ready=0 in RUN: pc_write=0, ir_write=0, stall_ifid=1, stall_idex=1, all flushes=0, and the counters SHALL hold.
REQ-030 Output priority in RUN SHALL be: freeze > branch miss > jump miss > data hazard.
- Branch miss: flush_ifid=1, flush_idex=1, pc_write=1, no issue.
- Jump miss: flush_ifid=1, pc_write=1, and the ID instruction still issues.
- Data hazard: pc_write=0, ir_write=0, stall_ifid=1, flush_idex=1.
- Otherwise: pc_write=1, ir_write=1, all stalls and flushes 0.
REQ-031 All outputs SHALL be combinational from the FSM state, the counters and the inputs, with zero-cycle latency.

Configuration
REQ-032 The macro HCU_FORWARD_EN SHALL select the counter load value:
- Defined: a load sets LOAD_LAT and a non-load sets 0.
- Undefined: every register-writing instruction sets WB_DIST.

Reset
REQ-033 While reset_n=0 at a clock edge: all counters SHALL be 0, the FSM SHALL be RUN and the pending branch flag SHALL be 0.
REQ-034 During reset, outputs SHALL read pc_write=1 and ir_write=1 with all stalls and flushes 0.
REQ-035 A reset asserted mid-freeze SHALL discard any latched branch miss.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding and the default values of WB_DIST and LOAD_LAT.
REQ-037 One sub-module, hcu_scoreboard, SHALL contain the counter array, with ports for set, clear, hold and two lookups.

Verification
REQ-038 Forwarding on: a load writing r1 issues, then an add reading r1 -> one cycle of stall_ifid=1 and flush_idex=1, and the add issues in the next cycle.
REQ-039 Forwarding off: an add writing r2, then an instruction reading r2 -> 3 stall cycles, then issue.
REQ-040 d_mem_ready=0 for 4 cycles with branch_miss_ex pulsed in the 2nd -> hcu_state goes 1, 2, 2, 2; then one cycle with flush_ifid=1 and flush_idex=1 after d_mem_ready rises; counters unchanged across the freeze.
REQ-041 branch_miss_ex and jump_miss_id together with a data hazard -> flush_ifid=1, flush_idex=1, pc_write=1 and no scoreboard update.
REQ-042 A dependent instruction re-issues to the same dest (r3) in the cycle its counter reaches 1 -> counter[r3] reloads to the new value rather than reaching 0.
REQ-043 reset_n=0 during FREEZE_PEND -> the next cycle is RUN, all counters are 0 and no flush occurs.
